// File: rtl/pc_pkg.sv
// Shared types and priority decode for the program-counter / return-address-stack block.
package pc_pkg;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_RET,
        OP_CALL,
        OP_JUMP,
        OP_INC
    } pc_op_e;

    // One action per cycle, highest priority first; reset is handled by the registers.
    function automatic pc_op_e pc_decode(input logic stall, input logic ret,
                                         input logic call, input logic jump_en);
        if (stall) begin
            return OP_HOLD;
        end else if (ret) begin
            return OP_RET;
        end else if (call) begin
            return OP_CALL;
        end else if (jump_en) begin
            return OP_JUMP;
        end
        return OP_INC;
    endfunction

endpackage

// File: rtl/pc_ras_stack.sv
// Circular return-address stack; a push while full overwrites the oldest entry.
module pc_ras_stack #(
    parameter int unsigned D     = 12,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [D-1:0]             wdata,
    output logic [D-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count
);
    import pc_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [D-1:0]  mem_q [DEPTH];
    logic [AW-1:0] sp_q, sp_d;
    logic [CW-1:0] count_q, count_d;

    // Next pointer/count; sp always names the next free slot, which is the oldest entry when full.
    always_comb begin
        sp_d    = sp_q;
        count_d = count_q;
        if (push) begin
            sp_d = sp_q + AW'(1);
            if (count_q != FULL_CNT) begin
                count_d = count_q + CW'(1);
            end
        end else if (pop && (count_q != '0)) begin
            sp_d    = sp_q - AW'(1);
            count_d = count_q - CW'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q    <= '0;
            count_q <= '0;
        end else begin
            sp_q    <= sp_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are not cleared by reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[sp_q] <= wdata;
        end
    end

    assign rdata = mem_q[sp_q - AW'(1)];
    assign count = count_q;

endmodule

// File: rtl/pc_ras.sv
// Program counter with increment/jump/call/ret and a return-address stack.
module pc_ras #(
    parameter int unsigned   D         = 12,
    parameter int unsigned   DEPTH     = 4,
    parameter logic [D-1:0]  RESET_VEC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     jump_en,
    input  logic                     abs_jump,
    input  logic                     call,
    input  logic                     ret,
    input  logic [D-1:0]             target,
    output logic [D-1:0]             prog_ctr,
    output logic [$clog2(DEPTH):0]   ras_count,
    output logic                     ras_empty,
    output logic                     ras_full,
    output logic                     ras_ovf,
    output logic                     ras_unf
);
    import pc_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    pc_op_e       op;
    logic [D-1:0] prog_ctr_q, prog_ctr_d;
    logic [D-1:0] pc_inc, jmp_tgt, rdata;
    logic         ovf_q, ovf_d, unf_q, unf_d;
    logic         push, pop;

    pc_ras_stack #(
        .D     (D),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (pc_inc),
        .rdata (rdata),
        .count (ras_count)
    );

    // Decode the single action for this cycle and form next PC, stack strobes and flags.
    always_comb begin
        op         = pc_decode(stall, ret, call, jump_en);
        pc_inc     = prog_ctr_q + D'(1);
        jmp_tgt    = abs_jump ? target : prog_ctr_q + target;
        prog_ctr_d = prog_ctr_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        push       = 1'b0;
        pop        = 1'b0;
        unique case (op)
            OP_RET: begin
                // A simultaneous call is dropped and flagged as an underflow-class error.
                if (call) begin
                    unf_d = 1'b1;
                end
                if (ras_empty) begin
                    unf_d      = 1'b1;
                    prog_ctr_d = pc_inc;
                end else begin
                    pop        = 1'b1;
                    prog_ctr_d = rdata;
                end
            end
            OP_CALL: begin
                push       = 1'b1;
                prog_ctr_d = jmp_tgt;
                if (ras_full) begin
                    ovf_d = 1'b1;
                end
            end
            OP_JUMP: prog_ctr_d = jmp_tgt;
            OP_INC:  prog_ctr_d = pc_inc;
            default: ;
        endcase
    end

    // PC and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            prog_ctr_q <= RESET_VEC;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            prog_ctr_q <= prog_ctr_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign prog_ctr  = prog_ctr_q;
    assign ras_empty = (ras_count == '0);
    assign ras_full  = (ras_count == CW'(DEPTH));
    assign ras_ovf   = ovf_q;
    assign ras_unf   = unf_q;

endmodule

// File: tb/tb_pc_ras.sv
// Directed bench for pc_ras with default parameters (D=12, DEPTH=4, RESET_VEC=0).
module tb_pc_ras;

    logic        clk = 1'b0;
    logic        reset, stall, jump_en, abs_jump, call, ret;
    logic [11:0] target;
    logic [11:0] prog_ctr;
    logic [2:0]  ras_count;
    logic        ras_empty, ras_full, ras_ovf, ras_unf;

    int tests = 0;
    int fails = 0;

    pc_ras dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .jump_en   (jump_en),
        .abs_jump  (abs_jump),
        .call      (call),
        .ret       (ret),
        .target    (target),
        .prog_ctr  (prog_ctr),
        .ras_count (ras_count),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_ovf   (ras_ovf),
        .ras_unf   (ras_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Set controls (reset, stall, jump_en, abs_jump, call, ret, target), then clock once.
    task automatic step(input logic rs, input logic st, input logic je, input logic ab,
                        input logic ca, input logic re, input logic [11:0] tg);
        reset = rs; stall = st; jump_en = je; abs_jump = ab; call = ca; ret = re; target = tg;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    endtask

    task automatic call_abs(input logic [11:0] tg);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, tg);
    endtask

    task automatic do_ret();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
    endtask

    task automatic jump(input logic ab, input logic [11:0] tg);
        step(1'b0, 1'b0, 1'b1, ab, 1'b0, 1'b0, tg);
    endtask

    initial begin
        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        chk("rst_pc", prog_ctr, 12'h000);
        chk("rst_cnt", ras_count, 3'd0);
        chk("rst_empty", ras_empty, 1'b1);
        chk("rst_full", ras_full, 1'b0);
        chk("rst_ovf", ras_ovf, 1'b0);
        chk("rst_unf", ras_unf, 1'b0);

        // Idle increments
        idle(); chk("inc1", prog_ctr, 12'h001);
        idle(); chk("inc2", prog_ctr, 12'h002);
        idle(); chk("inc3", prog_ctr, 12'h003);
        chk("inc_empty", ras_empty, 1'b1);

        // Call / ret round trip
        jump(1'b1, 12'h010); chk("jabs", prog_ctr, 12'h010);
        call_abs(12'h200);
        chk("call_pc", prog_ctr, 12'h200);
        chk("call_cnt", ras_count, 3'd1);
        chk("call_empty", ras_empty, 1'b0);
        idle(); chk("call_inc", prog_ctr, 12'h201);
        do_ret();
        chk("ret_pc", prog_ctr, 12'h011);
        chk("ret_cnt", ras_count, 3'd0);

        // Relative jump backwards, then wrap on increment
        jump(1'b1, 12'h005);
        jump(1'b0, 12'hFFE); chk("jrel", prog_ctr, 12'h003);
        jump(1'b1, 12'hFFF); chk("jfff", prog_ctr, 12'hFFF);
        idle(); chk("wrap", prog_ctr, 12'h000);

        // Five nested calls with DEPTH=4
        call_abs(12'h100);
        call_abs(12'h200);
        call_abs(12'h300);
        call_abs(12'h400);
        chk("n4_full", ras_full, 1'b1);
        chk("n4_ovf", ras_ovf, 1'b0);
        call_abs(12'h500);
        chk("n5_pc", prog_ctr, 12'h500);
        chk("n5_cnt", ras_count, 3'd4);
        chk("n5_ovf", ras_ovf, 1'b1);
        do_ret(); chk("r1_pc", prog_ctr, 12'h401);
        do_ret(); chk("r2_pc", prog_ctr, 12'h301);
        do_ret(); chk("r3_pc", prog_ctr, 12'h201);
        do_ret(); chk("r4_pc", prog_ctr, 12'h101);
        chk("r4_cnt", ras_count, 3'd0);
        chk("r4_unf", ras_unf, 1'b0);
        do_ret();
        chk("r5_pc", prog_ctr, 12'h102);
        chk("r5_unf", ras_unf, 1'b1);
        chk("r5_cnt", ras_count, 3'd0);
        chk("ovf_sticky", ras_ovf, 1'b1);

        // Stall with call, then call+ret together
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        chk("rst2_unf", ras_unf, 1'b0);
        call_abs(12'h020);
        call_abs(12'h040);
        chk("c2_cnt", ras_count, 3'd2);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h080);
        chk("stall_pc", prog_ctr, 12'h040);
        chk("stall_cnt", ras_count, 3'd2);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h080);
        chk("cr_pc", prog_ctr, 12'h021);
        chk("cr_cnt", ras_count, 3'd1);
        chk("cr_unf", ras_unf, 1'b1);
        chk("cr_ovf", ras_ovf, 1'b0);

        // Reset beats a ret with three entries pending
        call_abs(12'h060);
        call_abs(12'h070);
        chk("c3_cnt", ras_count, 3'd3);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        chk("rr_pc", prog_ctr, 12'h000);
        chk("rr_cnt", ras_count, 3'd0);
        chk("rr_empty", ras_empty, 1'b1);
        chk("rr_unf", ras_unf, 1'b0);
        chk("rr_ovf", ras_ovf, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
